btn_debounce_sync: RTL
======================

# btn_debounce_sync

Front-end conditioning stage for the board push-buttons. It synchronises N raw, asynchronous, bouncing button inputs into the system clock domain and debounces them with a shared millisecond-scale tick. It emits a clean level per button plus single-cycle rise/fall pulses. Its outputs feed the one-shot/edge-pulse stage and the control FSMs directly downstream, so no unsynchronised or bouncing signal reaches them.

## Interface
- N_BTN, 4, number of independent button channels (≥1)
- TICK_DIV, 100000, system clocks per debounce tick (≥1); 100000 = 1 ms at 100 MHz
- STABLE_TICKS, 10, consecutive ticks a new level must persist before it is accepted (≥1)

- clk  input  1  system clock (100 MHz nominal), all state on posedge
- rst_n  input  1  reset, asynchronous, active-low; one clock, no other clock domains
- btn_raw  input  N_BTN  raw button pins, asynchronous to clk, active-high
- btn_db  output  N_BTN  debounced level per channel, registered
- btn_rise  output  N_BTN  one-cycle pulse, high in the first cycle btn_db[i] is 1
- btn_fall  output  N_BTN  one-cycle pulse, high in the first cycle btn_db[i] is 0 after being 1
- tick  output  1  debounce tick strobe, one cycle every TICK_DIV cycles (debug/reuse)

## Operation
- Reset (rst_n low, async): sync stages, btn_db, btn_rise, btn_fall, all channel counters and the tick counter are cleared to 0. The tick output is 0. All outputs stay 0 until the reset is released.
- Tick generator: tick_cnt has width clog2(TICK_DIV) (min 1) and counts 0..TICK_DIV-1, then wraps to 0.
  - tick = (tick_cnt == TICK_DIV-1), combinational from the register.
  - TICK_DIV=1 gives tick high every cycle after reset.
- Synchroniser: each channel has a 2-FF chain btn_raw → s1 → s2. Only s2 is used downstream. The chain is never bypassed.
- Per-channel debounce (independent, identical) uses a counter of width clog2(STABLE_TICKS+1):
  - s2 == btn_db: counter ← 0 in every cycle, tick or not. Any bounce back therefore restarts qualification.
  - s2 != btn_db, tick=1, counter < STABLE_TICKS-1: counter ← counter+1.
  - s2 != btn_db, tick=1, counter == STABLE_TICKS-1: btn_db ← s2, counter ← 0.
  - s2 != btn_db, tick=0: counter holds.
- Edge outputs are registered together with btn_db:
  - btn_rise[i] ← (next btn_db[i]=1 and current btn_db[i]=0).
  - btn_fall[i] ← the converse.
  - Each is high for exactly one cycle per accepted transition. Rise and fall are never high together on one channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- A reset asserted mid-qualification discards the partial count. After release a held button qualifies again from scratch and yields a btn_rise.

## Timing
- Latency with TICK_DIV=1: btn_raw stable-changed before edge k gives btn_db/btn_rise valid after edge k+1+STABLE_TICKS. That is 2 sync edges plus STABLE_TICKS counting edges, with the flip on the last tick.
- General latency from s2 changing to btn_db: between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles, depending on tick phase. Add 2 cycles of sync.
- Minimum accepted pulse width: any s2 level held for fewer than STABLE_TICKS ticks is rejected entirely.
- btn_rise/btn_fall are aligned to the btn_db change edge with 0 additional latency.
- Counters never overflow: the maximum value is STABLE_TICKS-1 before clear.

## Test plan
- Reset: hold rst_n low with btn_raw=4'b1111 → all outputs 0. Release with TICK_DIV=1, STABLE_TICKS=3 → btn_db=4'b1111 and btn_rise=4'b1111 for one cycle, 5 edges after release.
- Clean press (TICK_DIV=1, STABLE_TICKS=3): btn_raw[0] 0→1 before edge 0 → btn_db[0]=1 and btn_rise[0]=1 after edge 4, rise low after edge 5. Releasing gives btn_fall[0] likewise.
- Bounce rejection (TICK_DIV=1, STABLE_TICKS=3): btn_raw[1] toggles 1,0,1,0 with a 2-cycle period, then holds 1 → no pulse during bouncing. A single btn_rise[1] occurs 5 edges after the final stable 1.
- Tick gating (TICK_DIV=4, STABLE_TICKS=2): check tick period is 4 cycles. A press held 3 cycles → no change. A press held 20 cycles → exactly one btn_rise, 6–10 cycles after the raw edge.
- Simultaneous channels: btn_raw 4'b0000→4'b1010 on the same edge → btn_rise=4'b1010 in a single cycle, btn_fall=0.
- Reset mid-operation: assert rst_n for 1 cycle while channel 2 counter=2 (STABLE_TICKS=3) → outputs and counters clear immediately. The held input re-qualifies 5 edges after release with one btn_rise[2].

Source files
------------

// File: rtl/btn_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_sync
//  Description : Synchronises and debounces N asynchronous push-button inputs
//                against a shared divided tick; emits clean levels and
//                single-cycle rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_sync #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic             tick
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CNT_W  = $clog2(STABLE_TICKS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(STABLE_TICKS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                r_run;
    logic                w_tick;
    logic [N_BTN-1:0]    r_sync1;
    logic [N_BTN-1:0]    r_sync2;

    // r_run keeps tick low while in reset even when TICK_DIV == 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_tick_cnt == c_TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
            end
        end
    end

    assign w_tick = r_run & (r_tick_cnt == c_TICK_LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_db;
            logic               r_rise;
            logic               r_fall;

            // Any return of s2 to the accepted level restarts qualification.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt  <= '0;
                    r_db   <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (r_sync2[i] == r_db) begin
                        r_cnt <= '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_db   <= r_sync2[i];
                            r_cnt  <= '0;
                            r_rise <= r_sync2[i];
                            r_fall <= ~r_sync2[i];
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
            end

            assign btn_db[i]   = r_db;
            assign btn_rise[i] = r_rise;
            assign btn_fall[i] = r_fall;
        end
    endgenerate

endmodule
`default_nettype wire
